// File: rtl/grad_accum_sched.sv
// Gradient accumulator: sums |green_h - green_v| over NUM_PAIRS pairs per window and
// presents the sum plus an edge flag downstream. Optional clipping via `GRAD_CLIP_EN.

module abs_diff #(
    parameter int pixelBitWidth = 14
) (
    input  logic [pixelBitWidth-1:0] a,
    input  logic [pixelBitWidth-1:0] b,
    output logic [pixelBitWidth-1:0] y
);
    assign y = (a >= b) ? (a - b) : (b - a);
endmodule

module grad_accum_sched #(
    parameter  int pixelBitWidth = 14,
    parameter  int NUM_PAIRS     = 4,
    localparam int CNT_W         = $clog2(NUM_PAIRS),
    localparam int ACC_W         = pixelBitWidth - 1 + CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [pixelBitWidth-1:0] green_h,
    input  logic [pixelBitWidth-1:0] green_v,
    input  logic                     flush,
    input  logic [ACC_W-1:0]         threshold,
`ifdef GRAD_CLIP_EN
    input  logic [pixelBitWidth-2:0] clip_level,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         grad_sum,
    output logic                     edge_flag,
    output logic [CNT_W-1:0]         win_cnt
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         win_cnt_q, win_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         grad_sum_q, grad_sum_d;
    logic                     edge_flag_q, edge_flag_d;
    logic                     in_ready_q, in_ready_d;

    logic [pixelBitWidth-1:0] abs_full;
    logic                     abs_msb_unused;
    logic [pixelBitWidth-2:0] term_raw;
    logic [pixelBitWidth-2:0] term_sel;
    logic [ACC_W-1:0]         term;
    logic [ACC_W-1:0]         sum_full;
    logic                     accept;

`ifdef GRAD_CLIP_EN
    function automatic logic [pixelBitWidth-2:0] clip_term(
        input logic [pixelBitWidth-2:0] t,
        input logic [pixelBitWidth-2:0] lim
    );
        return (t > lim) ? lim : t;
    endfunction
`endif

    abs_diff #(
        .pixelBitWidth(pixelBitWidth)
    ) u_abs_diff (
        .a(green_h),
        .b(green_v),
        .y(abs_full)
    );

    // The abs term keeps only its low pixelBitWidth-1 bits; the MSB is dropped by design.
    assign abs_msb_unused = abs_full[pixelBitWidth-1];
    assign term_raw       = abs_full[pixelBitWidth-2:0];

`ifdef GRAD_CLIP_EN
    assign term_sel = clip_term(term_raw, clip_level);
`else
    assign term_sel = term_raw;
`endif

    assign term     = {{CNT_W{1'b0}}, term_sel};
    assign sum_full = acc_q + term;
    assign accept   = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        win_cnt_d   = win_cnt_q;
        out_valid_d = out_valid_q;
        grad_sum_d  = grad_sum_q;
        edge_flag_d = edge_flag_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_ACC: begin
                // flush has priority over an accept in the same cycle; the pair is dropped.
                if (flush) begin
                    acc_d     = '0;
                    win_cnt_d = '0;
                end else if (accept) begin
                    if (win_cnt_q == CNT_W'(NUM_PAIRS - 1)) begin
                        grad_sum_d  = sum_full;
                        edge_flag_d = (sum_full > threshold);
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        win_cnt_d   = '0;
                        in_ready_d  = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d     = sum_full;
                        win_cnt_d = win_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d    = ST_ACC;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            grad_sum_q  <= '0;
            edge_flag_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            win_cnt_q   <= win_cnt_d;
            out_valid_q <= out_valid_d;
            grad_sum_q  <= grad_sum_d;
            edge_flag_q <= edge_flag_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign grad_sum  = grad_sum_q;
    assign edge_flag = edge_flag_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: doc/grad_accum_sched.md
Name: grad_accum_sched

Overview:
- Sequences one shared abs_diff datapath across a window of NUM_PAIRS green_h/green_v candidate pairs per CFA pixel.
- Accepts one pair per cycle over a valid/ready stream and accumulates the per-pair absolute differences into a gradient sum.
- When a window completes, presents the sum plus an edge flag (sum > threshold) downstream and holds it until accepted.
- Sits between the green-interpolation candidate generator and the direction-decision logic.

Parameters:
- pixelBitWidth, 14, pixel width; per-pair abs term is pixelBitWidth-1 bits.
- NUM_PAIRS, 4, pairs per window; power of two, 2..16.
- ACC_W, pixelBitWidth-1+$clog2(NUM_PAIRS), accumulator/result width; local, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  pair present on green_h/green_v
- in_ready  output  1  block can accept a pair this cycle
- green_h  input  pixelBitWidth  horizontal green candidate
- green_v  input  pixelBitWidth  vertical green candidate
- flush  input  1  abort current partial window
- threshold  input  ACC_W  edge threshold, sampled at window completion
- out_valid  output  1  grad_sum/edge_flag valid
- out_ready  input  1  downstream accepts result
- grad_sum  output  ACC_W  sum of window abs terms
- edge_flag  output  1  grad_sum > threshold (unsigned, strict)
- win_cnt  output  $clog2(NUM_PAIRS)  pairs accepted in current window

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=ACC, acc=0, win_cnt=0, out_valid=0, grad_sum=0, edge_flag=0, in_ready=1 the cycle after rst deasserts.
- Abs term: instantiates the existing abs_diff (parameter pixelBitWidth) on green_h/green_v combinationally.
  - Term = |green_h - green_v| truncated to its low pixelBitWidth-1 bits, zero-extended to ACC_W.
- Accept: a pair is accepted on any cycle with in_valid && in_ready.
- FSM state ACC (in_ready=1):
  - Accept with win_cnt<NUM_PAIRS-1: acc += term; win_cnt++.
  - Accept with win_cnt==NUM_PAIRS-1:
    - grad_sum <= acc+term;
    - edge_flag <= (acc+term) > threshold;
    - out_valid <= 1; acc <= 0; win_cnt <= 0; next state HOLD.
  - Latency: result is visible the cycle after the last accept.
- FSM state HOLD (in_ready=0):
  - grad_sum and edge_flag are held stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0, next state ACC.
  - One bubble cycle per window; max throughput is NUM_PAIRS pairs per NUM_PAIRS+1 cycles.
- flush:
  - In ACC, flush wins over a simultaneous accept: acc <= 0, win_cnt <= 0, pair discarded.
  - In HOLD, flush has no effect; the pending result is still delivered.
- Overflow: ACC_W is sized for NUM_PAIRS*(2^(pixelBitWidth-1)-1), so there is no wrap.
- Reset mid-window or mid-HOLD: partial sum and pending result are dropped; out_valid is 0 the next cycle.
- in_valid without in_ready: the pair is not consumed; the source must hold it.

Optional Feature:
- Macro: GRAD_CLIP_EN.
- Defined:
  - Adds input clip_level [pixelBitWidth-2:0].
  - Each abs term is replaced by min(term, clip_level) before accumulation, limiting single-outlier influence.
  - clip_level=0 forces grad_sum=0.
- Undefined: no clip_level port; raw terms are accumulated.

Test Plan:
- Reset check: assert rst 2 cycles -> out_valid=0, grad_sum=0, win_cnt=0; in_ready=1 the cycle after release.
- Basic window (14-bit, NUM_PAIRS=4, threshold=8000): pairs (100,40),(40,100),(0,16383),(5,5) back-to-back, out_ready=1.
  - Required: next cycle out_valid=1, grad_sum=8311 (60+60+8191+0, truncation), edge_flag=1.
  - in_ready=0 for exactly 1 cycle.
- Backpressure: same window with out_ready=0 for 5 cycles -> grad_sum=8311 held stable, in_ready=0 throughout; out_valid drops the cycle after out_ready=1.
- Flush: accept (10,0),(20,0); flush with in_valid=1 on a (30,0) pair; then (1,0)x4 -> grad_sum=4, edge_flag=0 (threshold=4, strict compare).
- Mid-window reset: accept 3 pairs, assert rst, then 4 pairs of (7,2) -> grad_sum=20; the earlier partial sum does not contribute.
- GRAD_CLIP_EN with clip_level=50: pairs (100,40),(40,100),(0,16383),(5,5) -> grad_sum=150.
